// File: rtl/tinynpu_layer_seq.sv
// tinynpu_layer_seq: host-side sequencer feeding the TinyNPU controller.
// Tile 0 fetches the x vector and a SIZE x SIZE weight tile from a shared
// single-port memory, loads them, and triggers MAC. Each later tile reloads
// only weights, because the NPU recirculates outputs into its x FIFO. After
// the last tile, the output phase is requested and done is pulsed.
//
// Ports:
//   clk, rst (async, active-low)
//   start, cfg_base_x, cfg_base_w, cfg_tiles : job launch/config (captured on start)
//   busy, done                               : job status
//   mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata : one-outstanding read port
//   npu_x_load_val, npu_w_load_val, npu_w_load_sel, npu_load_data : load strobes
//   npu_mac_val, npu_out_val                 : NPU phase requests
//   npu_state                                : NPU state trace (0 LD0,1 MAC,2 LD1,3 OUT)
//   perf_cycles                              : busy-cycle counter, only with
//                                              TINYNPU_SEQ_PERF_EN defined
module tinynpu_layer_seq #(
  parameter int unsigned SIZE = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AW-1:0]           cfg_base_x,
  input  logic [AW-1:0]           cfg_base_w,
  input  logic [7:0]              cfg_tiles,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req,
  output logic [AW-1:0]           mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    npu_x_load_val,
  output logic                    npu_w_load_val,
  output logic [$clog2(SIZE)-1:0] npu_w_load_sel,
  output logic [DW-1:0]           npu_load_data,
  output logic                    npu_mac_val,
  output logic                    npu_out_val,
  input  logic [3:0]              npu_state
`ifdef TINYNPU_SEQ_PERF_EN
  ,
  output logic [15:0]             perf_cycles
`endif
);

  localparam int unsigned SW = $clog2(SIZE);
  localparam int unsigned IW = $clog2(SIZE * SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_LDX, S_LDW, S_MAC, S_WAIT, S_OUTQ, S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   bx_q, bx_d, bw_q, bw_d;
  logic [7:0]      tiles_q, tiles_d, tile_q, tile_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            req_q, req_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            xv_q, xv_d, wv_q, wv_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   w_off, fetch_addr;
  logic [IW-1:0]   last_idx;

  assign w_off      = AW'(32'(tile_q) * SIZE * SIZE);
  assign fetch_addr = (state_q == S_LDX) ? bx_q + AW'(idx_q)
                                         : bw_q + w_off + AW'(idx_q);
  assign last_idx   = (state_q == S_LDX) ? IW'(SIZE - 1) : IW'(SIZE * SIZE - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bx_q    <= '0;
      bw_q    <= '0;
      tiles_q <= '0;
      tile_q  <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      xv_q    <= 1'b0;
      wv_q    <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      bw_q    <= bw_d;
      tiles_q <= tiles_d;
      tile_q  <= tile_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      xv_q    <= xv_d;
      wv_q    <= wv_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    bw_d    = bw_q;
    tiles_d = tiles_q;
    tile_d  = tile_q;
    idx_d   = idx_q;
    req_d   = req_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    xv_d    = 1'b0;
    wv_d    = 1'b0;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LDX;
          bx_d    = cfg_base_x;
          bw_d    = cfg_base_w;
          tiles_d = (cfg_tiles == 8'd0) ? 8'd1 : cfg_tiles;
          tile_d  = '0;
          idx_d   = '0;
        end
      end
      S_LDX, S_LDW: begin
        // Request -> grant -> rvalid, strictly one read in flight. An rvalid
        // while nothing is pending (including during req) is ignored.
        if (!req_q && !pend_q) begin
          req_d  = 1'b1;
          addr_d = fetch_addr;
        end else if (req_q && mem_gnt) begin
          req_d  = 1'b0;
          pend_d = 1'b1;
        end else if (pend_q && mem_rvalid) begin
          pend_d = 1'b0;
          data_d = mem_rdata;
          if (state_q == S_LDX) begin
            xv_d = 1'b1;
          end else begin
            wv_d  = 1'b1;
            sel_d = SW'(idx_q / IW'(SIZE));
          end
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = (state_q == S_LDX) ? S_LDW : S_MAC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        // mac is held off while the final weight strobe is still on the bus.
        if (!wv_q && npu_state == 4'd1) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (npu_state == 4'd2) begin
          if ((9'(tile_q) + 9'd1) < 9'(tiles_q)) begin
            tile_d  = tile_q + 8'd1;
            idx_d   = '0;
            state_d = S_LDW;
          end else begin
            state_d = S_OUTQ;
          end
        end
      end
      S_OUTQ: begin
        if (npu_state == 4'd3) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done           = (state_q == S_FIN);
  assign mem_req        = req_q;
  assign mem_addr       = addr_q;
  assign npu_x_load_val = xv_q;
  assign npu_w_load_val = wv_q;
  assign npu_w_load_sel = sel_q;
  assign npu_load_data  = data_q;
  assign npu_mac_val    = (state_q == S_MAC) && !wv_q;
  assign npu_out_val    = (state_q == S_OUTQ);

`ifdef TINYNPU_SEQ_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_q <= '0;
    end else if (busy && perf_q != '1) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tinynpu_layer_seq.sv
module tb_tinynpu_layer_seq;
  localparam int SIZE = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base_x = '0;
  logic [AW-1:0] cfg_base_w = '0;
  logic [7:0]    cfg_tiles = '0;
  logic          busy, done, mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          npu_x_load_val, npu_w_load_val, npu_mac_val, npu_out_val;
  logic [1:0]    npu_w_load_sel;
  logic [DW-1:0] npu_load_data;
  logic [3:0]    npu_state = 4'd0;
`ifdef TINYNPU_SEQ_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  int chk = 0;
  int err = 0;

  always #5 clk = ~clk;

  tinynpu_layer_seq #(.SIZE(SIZE), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_x(cfg_base_x), .cfg_base_w(cfg_base_w), .cfg_tiles(cfg_tiles),
    .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .npu_x_load_val(npu_x_load_val), .npu_w_load_val(npu_w_load_val),
    .npu_w_load_sel(npu_w_load_sel), .npu_load_data(npu_load_data),
    .npu_mac_val(npu_mac_val), .npu_out_val(npu_out_val),
    .npu_state(npu_state)
`ifdef TINYNPU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  function automatic logic [7:0] memf(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Memory model: grants after stall_cfg cycles, returns data 1 cycle after gnt.
  bit         mem_manual = 1'b0;
  logic       man_gnt = 1'b0, man_rv = 1'b0;
  logic [7:0] man_data = '0;
  int         stall_cfg = 0;
  int         left = 0;
  bit         in_req = 1'b0;
  logic [7:0] held_addr = '0, gaddr = '0;
  int         stab_ok = 0, stab_err = 0;

  always @(negedge clk) begin
    if (mem_manual) begin
      mem_gnt = man_gnt; mem_rvalid = man_rv; mem_rdata = man_data; in_req = 1'b0;
    end else if (!rst) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; in_req = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (mem_gnt) begin mem_rvalid = 1'b1; mem_rdata = memf(gaddr); end
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1'b1; left = stall_cfg; held_addr = mem_addr;
        end else if (mem_addr !== held_addr) stab_err++;
        else stab_ok++;
        if (left > 0) left--;
        else begin mem_gnt = 1'b1; gaddr = mem_addr; in_req = 1'b0; end
      end else if (in_req) begin
        stab_err++; in_req = 1'b0;
      end
    end
  end

  // NPU model: MAC for a few cycles then LD1; out request -> OUT.
  int ncnt = 0;
  always @(negedge clk) begin
    if (!rst) begin npu_state = 4'd0; ncnt = 0; end
    else if (npu_state == 4'd1) begin
      if (ncnt == 0) npu_state = 4'd2; else ncnt--;
    end
    else if (npu_mac_val) begin npu_state = 4'd1; ncnt = 2; end
    else if (npu_out_val) npu_state = 4'd3;
    else if (npu_state == 4'd3 && !busy) npu_state = 4'd0;
  end

  // Event logger.
  logic [7:0]  x_log[$];
  logic [15:0] w_log[$];
  int mac_pulses = 0, out_pulses = 0, done_n = 0, busy_cyc = 0, out_mac_at = 0, ovl = 0;
  bit mac_prev = 1'b0, out_prev = 1'b0;
  always @(negedge clk) begin
    if (npu_x_load_val) x_log.push_back(npu_load_data);
    if (npu_w_load_val) w_log.push_back({6'b0, npu_w_load_sel, npu_load_data});
    if (npu_mac_val && !mac_prev) mac_pulses++;
    if (npu_out_val && !out_prev) begin out_pulses++; out_mac_at = mac_pulses; end
    if (npu_mac_val && (npu_out_val || npu_x_load_val || npu_w_load_val)) ovl++;
    if (done && busy) ovl++;
    if (done) done_n++;
    if (busy) busy_cyc++;
    mac_prev = npu_mac_val;
    out_prev = npu_out_val;
  end

  task automatic run_job(input logic [7:0] tiles, input logic [7:0] bx, input logic [7:0] bw,
                         input int restart_at, input int budget);
    int  n;
    int  d0;
    bit  ok;
    d0 = done_n;
    @(negedge clk);
    start = 1'b1; cfg_tiles = tiles; cfg_base_x = bx; cfg_base_w = bw;
    @(negedge clk);
    start = 1'b0;
    cfg_base_x = 8'hC0; cfg_base_w = 8'hE0; cfg_tiles = 8'd7;
    chk++;
    if (busy !== 1'b1) begin err++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
      if (done_n != d0) ok = 1'b1;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk++;
    if (!ok) begin err++; $display("FAIL job_timeout got=no_done exp=done within %0d", budget); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    chk++; if (done !== 1'b0) begin err++; $display("FAIL rst_done got=%b exp=0", done); end
    chk++; if ({mem_req, mem_addr} !== 9'd0) begin err++; $display("FAIL rst_mem got=%h exp=0", {mem_req, mem_addr}); end
    chk++;
    if ({npu_x_load_val, npu_w_load_val, npu_w_load_sel, npu_load_data, npu_mac_val, npu_out_val} !== 14'd0) begin
      err++; $display("FAIL rst_npu got=%h exp=0",
        {npu_x_load_val, npu_w_load_val, npu_w_load_sel, npu_load_data, npu_mac_val, npu_out_val});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int xs, ws, m0, o0, d0, b0;
    xs = x_log.size(); ws = w_log.size(); m0 = mac_pulses; o0 = out_pulses; d0 = done_n; b0 = busy_cyc;
    run_job(8'd1, 8'h00, 8'h10, 0, 2000);
    chk++; if (x_log.size() - xs != 4) begin err++; $display("FAIL single_xcount got=%0d exp=4", x_log.size() - xs); end
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (xs + i >= x_log.size() || x_log[xs+i] !== memf(8'(i))) begin
        err++; $display("FAIL single_x%0d got=%h exp=%h", i, x_log[xs+i], memf(8'(i)));
      end
    end
    chk++; if (w_log.size() - ws != 16) begin err++; $display("FAIL single_wcount got=%0d exp=16", w_log.size() - ws); end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] e;
      e = {6'b0, 2'(i / 4), memf(8'(8'h10 + i))};
      chk++;
      if (ws + i >= w_log.size() || w_log[ws+i] !== e) begin
        err++; $display("FAIL single_w%0d got=%h exp=%h", i, w_log[ws+i], e);
      end
    end
    chk++; if (mac_pulses - m0 != 1) begin err++; $display("FAIL single_mac got=%0d exp=1", mac_pulses - m0); end
    chk++; if (out_pulses - o0 != 1) begin err++; $display("FAIL single_out got=%0d exp=1", out_pulses - o0); end
    chk++; if (out_mac_at != m0 + 1) begin err++; $display("FAIL single_out_order got=%0d exp=%0d", out_mac_at, m0 + 1); end
    chk++; if (done_n - d0 != 1) begin err++; $display("FAIL single_done got=%0d exp=1", done_n - d0); end
`ifdef TINYNPU_SEQ_PERF_EN
    chk++;
    if (perf_cycles !== 16'(busy_cyc - b0)) begin
      err++; $display("FAIL perf_count got=%0d exp=%0d", perf_cycles, busy_cyc - b0);
    end
`endif
  endtask

  task automatic test_multi_tile();
    int xs, ws, m0, o0, d0;
    xs = x_log.size(); ws = w_log.size(); m0 = mac_pulses; o0 = out_pulses; d0 = done_n;
    run_job(8'd3, 8'h00, 8'h10, 0, 4000);
    chk++; if (x_log.size() - xs != 4) begin err++; $display("FAIL multi_xcount got=%0d exp=4", x_log.size() - xs); end
    chk++; if (w_log.size() - ws != 48) begin err++; $display("FAIL multi_wcount got=%0d exp=48", w_log.size() - ws); end
    for (int i = 0; i < 48; i++) begin
      logic [15:0] e;
      e = {6'b0, 2'((i % 16) / 4), memf(8'(8'h10 + i))};
      chk++;
      if (ws + i >= w_log.size() || w_log[ws+i] !== e) begin
        err++; $display("FAIL multi_w%0d got=%h exp=%h", i, w_log[ws+i], e);
      end
    end
    chk++; if (mac_pulses - m0 != 3) begin err++; $display("FAIL multi_mac got=%0d exp=3", mac_pulses - m0); end
    chk++; if (out_pulses - o0 != 1) begin err++; $display("FAIL multi_out got=%0d exp=1", out_pulses - o0); end
    chk++; if (out_mac_at != m0 + 3) begin err++; $display("FAIL multi_out_order got=%0d exp=%0d", out_mac_at, m0 + 3); end
    chk++; if (done_n - d0 != 1) begin err++; $display("FAIL multi_done got=%0d exp=1", done_n - d0); end
  endtask

  task automatic test_gnt_stall();
    int xs, ws, s0, e0;
    xs = x_log.size(); ws = w_log.size(); s0 = stab_ok; e0 = stab_err;
    stall_cfg = 5;
    run_job(8'd1, 8'h40, 8'h50, 0, 3000);
    stall_cfg = 0;
    chk++; if (stab_err != e0) begin err++; $display("FAIL stall_stable got=%0d exp=0", stab_err - e0); end
    chk++; if (stab_ok - s0 != 100) begin err++; $display("FAIL stall_cycles got=%0d exp=100", stab_ok - s0); end
    chk++; if (x_log.size() - xs != 4) begin err++; $display("FAIL stall_xcount got=%0d exp=4", x_log.size() - xs); end
    chk++; if (w_log.size() - ws != 16) begin err++; $display("FAIL stall_wcount got=%0d exp=16", w_log.size() - ws); end
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (xs + i >= x_log.size() || x_log[xs+i] !== memf(8'(8'h40 + i))) begin
        err++; $display("FAIL stall_x%0d got=%h exp=%h", i, x_log[xs+i], memf(8'(8'h40 + i)));
      end
    end
    for (int i = 0; i < 16; i++) begin
      chk++;
      if (ws + i >= w_log.size() || w_log[ws+i][7:0] !== memf(8'(8'h50 + i))) begin
        err++; $display("FAIL stall_w%0d got=%h exp=%h", i, w_log[ws+i][7:0], memf(8'(8'h50 + i)));
      end
    end
  endtask

  task automatic test_tiles0_restart();
    int xs, ws, m0, d0;
    xs = x_log.size(); ws = w_log.size(); m0 = mac_pulses; d0 = done_n;
    run_job(8'd0, 8'h08, 8'h20, 10, 2000);
    chk++; if (mac_pulses - m0 != 1) begin err++; $display("FAIL t0_mac got=%0d exp=1", mac_pulses - m0); end
    chk++; if (done_n - d0 != 1) begin err++; $display("FAIL t0_done got=%0d exp=1", done_n - d0); end
    chk++; if (w_log.size() - ws != 16) begin err++; $display("FAIL t0_wcount got=%0d exp=16", w_log.size() - ws); end
    for (int i = 0; i < 4; i++) begin
      chk++;
      if (xs + i >= x_log.size() || x_log[xs+i] !== memf(8'(8'h08 + i))) begin
        err++; $display("FAIL t0_x%0d got=%h exp=%h", i, x_log[xs+i], memf(8'(8'h08 + i)));
      end
    end
    chk++;
    if (ws + 15 >= w_log.size() || w_log[ws+15] !== {6'b0, 2'd3, memf(8'h2F)}) begin
      err++; $display("FAIL t0_wlast got=%h exp=%h", w_log[ws+15], {6'b0, 2'd3, memf(8'h2F)});
    end
  endtask

  task automatic test_reset_mid();
    int  xs, ws, n;
    bit  hit;
    ws = w_log.size();
    @(negedge clk);
    start = 1'b1; cfg_tiles = 8'd1; cfg_base_x = 8'h00; cfg_base_w = 8'h10;
    @(negedge clk);
    start = 1'b0;
    n = 0; hit = 1'b0;
    while (n < 500 && !hit) begin
      @(posedge clk); #1;
      n++;
      if (w_log.size() - ws >= 2 && mem_req && !mem_gnt) hit = 1'b1;
    end
    chk++;
    if (!hit) begin err++; $display("FAIL midrst_reach got=timeout exp=LDW request"); end
    man_gnt = 1'b1; man_rv = 1'b0; mem_manual = 1'b1;
    @(posedge clk); #1;
    man_gnt = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    xs = x_log.size(); ws = w_log.size();
    chk++;
    if ({busy, done, mem_req, mem_addr, npu_x_load_val, npu_w_load_val, npu_w_load_sel,
         npu_load_data, npu_mac_val, npu_out_val} !== 25'd0) begin
      err++; $display("FAIL midrst_outputs got=%h exp=0",
        {busy, done, mem_req, mem_addr, npu_x_load_val, npu_w_load_val, npu_w_load_sel,
         npu_load_data, npu_mac_val, npu_out_val});
    end
    @(posedge clk); #1;
    rst = 1'b1; man_rv = 1'b1; man_data = 8'hEE;
    @(posedge clk); #1;
    man_rv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk++;
    if (x_log.size() != xs || w_log.size() != ws) begin
      err++; $display("FAIL midrst_stale got=%0d strobes exp=0", x_log.size() - xs + w_log.size() - ws);
    end
    chk++;
    if ({busy, mem_req, npu_load_data} !== 10'd0) begin
      err++; $display("FAIL midrst_idle got=%h exp=0", {busy, mem_req, npu_load_data});
    end
    mem_manual = 1'b0;
    repeat (2) @(negedge clk);
    test_single();
  endtask

`ifdef TINYNPU_SEQ_PERF_EN
  task automatic test_perf_sat();
    stall_cfg = 3600;
    run_job(8'd1, 8'h00, 8'h10, 0, 80000);
    stall_cfg = 0;
    chk++;
    if (perf_cycles !== 16'hFFFF) begin err++; $display("FAIL perf_sat got=%h exp=ffff", perf_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi_tile();
    test_gnt_stall();
    test_tiles0_restart();
    test_reset_mid();
`ifdef TINYNPU_SEQ_PERF_EN
    test_perf_sat();
`endif
    chk++;
    if (ovl != 0) begin err++; $display("FAIL overlap got=%0d exp=0", ovl); end
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
